// File: rtl/perf_mon_pkg.sv
// Shared types and defaults for the branch performance monitor.
// PERF_MON_SATURATE_EN selects saturating counters instead of wrapping ones.
package perf_mon_pkg;

  typedef enum logic {
    PM_IDLE = 1'b0,
    PM_RUN  = 1'b1
  } pm_state_e;

  localparam int PM_CNT_W_DEF = 32;

  // Snapshot layout at the default counter width, as seen by firmware.
  typedef struct packed {
    logic [PM_CNT_W_DEF-1:0] retire;
    logic [PM_CNT_W_DEF-1:0] branch;
    logic [PM_CNT_W_DEF-1:0] mispredict;
  } pm_snap_t;

  function automatic logic pm_is_run(input pm_state_e s);
    return (s == PM_RUN);
  endfunction

endpackage

// File: rtl/perf_event_counter.sv
// Single event counter: +1 per enabled cycle, synchronous clear.
// Wraps by default; saturates at all-ones when PERF_MON_SATURATE_EN is defined.
module perf_event_counter
  import perf_mon_pkg::*;
#(
  parameter int CNT_W = PM_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf_pulse
);

  logic at_max;
  logic bump;

  assign at_max    = &cnt;
  assign bump      = en & inc & ~clr;
  // Pulses whenever an increment is attempted at all-ones, in either mode.
  assign ovf_pulse = bump & at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (bump) begin
`ifdef PERF_MON_SATURATE_EN
      if (!at_max) begin
        cnt <= cnt + CNT_W'(1);
      end
`else
      cnt <= cnt + CNT_W'(1);
`endif
    end
  end

endmodule

// File: rtl/branch_perf_monitor.sv
// Counts retires, branches and mispredictions inside a start/stop window and
// hands out a frozen snapshot. PERF_MON_SATURATE_EN selects saturating counters.
module branch_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int CNT_W = PM_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_start,
  input  logic             ctrl_stop,
  input  logic             ctrl_clear,
  input  logic             ev_retire,
  input  logic             ev_branch,
  input  logic             ev_mispredict,
  input  logic             snap_req,
  input  logic             snap_ack,
  output logic             snap_valid,
  output logic [CNT_W-1:0] snap_retire,
  output logic [CNT_W-1:0] snap_branch,
  output logic [CNT_W-1:0] snap_mispredict,
  output logic             running,
  output logic             ovf
);

  typedef struct packed {
    logic [CNT_W-1:0] retire;
    logic [CNT_W-1:0] branch;
    logic [CNT_W-1:0] mispredict;
  } snap_regs_t;

  pm_state_e  state;
  snap_regs_t live;
  snap_regs_t snap;
  logic       count_en;
  logic [2:0] ovf_pulse;

  assign count_en = pm_is_run(state);

  // Stop beats start when both arrive together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PM_IDLE;
      running <= 1'b0;
    end else begin
      case (state)
        PM_IDLE: begin
          if (ctrl_start && !ctrl_stop) begin
            state   <= PM_RUN;
            running <= 1'b1;
          end
        end
        PM_RUN: begin
          if (ctrl_stop) begin
            state   <= PM_IDLE;
            running <= 1'b0;
          end
        end
        default: begin
          state   <= PM_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  perf_event_counter #(.CNT_W(CNT_W)) u_cnt_retire (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (ev_retire),
    .en        (count_en),
    .clr       (ctrl_clear),
    .cnt       (live.retire),
    .ovf_pulse (ovf_pulse[0])
  );

  perf_event_counter #(.CNT_W(CNT_W)) u_cnt_branch (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (ev_branch),
    .en        (count_en),
    .clr       (ctrl_clear),
    .cnt       (live.branch),
    .ovf_pulse (ovf_pulse[1])
  );

  perf_event_counter #(.CNT_W(CNT_W)) u_cnt_mispredict (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (ev_mispredict),
    .en        (count_en),
    .clr       (ctrl_clear),
    .cnt       (live.mispredict),
    .ovf_pulse (ovf_pulse[2])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (ctrl_clear) begin
      ovf <= 1'b0;
    end else if (|ovf_pulse) begin
      ovf <= 1'b1;
    end
  end

  // Handshake: snap_req is accepted only while snap_valid=0 and captures the
  // live counts as they stand before this edge; snap_valid then holds with
  // stable data until snap_ack is seen, and requests during the hold are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap       <= '0;
      snap_valid <= 1'b0;
    end else if (!snap_valid) begin
      if (snap_req) begin
        snap       <= live;
        snap_valid <= 1'b1;
      end
    end else if (snap_ack) begin
      snap_valid <= 1'b0;
    end
  end

  assign snap_retire     = snap.retire;
  assign snap_branch     = snap.branch;
  assign snap_mispredict = snap.mispredict;

endmodule

// File: tb/tb_branch_perf_monitor.sv
// Directed bench for branch_perf_monitor: a 32-bit instance for window,
// snapshot and reset behaviour, and a 4-bit instance for wrap/saturate and clear.
module tb_branch_perf_monitor;

  logic clk = 1'b0;
  logic rst_n;

  logic        ctrl_start, ctrl_stop, ctrl_clear;
  logic        ev_retire, ev_branch, ev_mispredict;
  logic        snap_req, snap_ack;
  logic        snap_valid, running, ovf;
  logic [31:0] snap_retire, snap_branch, snap_mispredict;

  logic        s_start, s_stop, s_clear, s_retire, s_branch, s_mispredict;
  logic        s_req, s_ack;
  logic        s_valid, s_running, s_ovf;
  logic [3:0]  s_snap_retire, s_snap_branch, s_snap_mispredict;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_perf_monitor #(.CNT_W(32)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ctrl_start      (ctrl_start),
    .ctrl_stop       (ctrl_stop),
    .ctrl_clear      (ctrl_clear),
    .ev_retire       (ev_retire),
    .ev_branch       (ev_branch),
    .ev_mispredict   (ev_mispredict),
    .snap_req        (snap_req),
    .snap_ack        (snap_ack),
    .snap_valid      (snap_valid),
    .snap_retire     (snap_retire),
    .snap_branch     (snap_branch),
    .snap_mispredict (snap_mispredict),
    .running         (running),
    .ovf             (ovf)
  );

  branch_perf_monitor #(.CNT_W(4)) u_dut4 (
    .clk             (clk),
    .rst_n           (rst_n),
    .ctrl_start      (s_start),
    .ctrl_stop       (s_stop),
    .ctrl_clear      (s_clear),
    .ev_retire       (s_retire),
    .ev_branch       (s_branch),
    .ev_mispredict   (s_mispredict),
    .snap_req        (s_req),
    .snap_ack        (s_ack),
    .snap_valid      (s_valid),
    .snap_retire     (s_snap_retire),
    .snap_branch     (s_snap_branch),
    .snap_mispredict (s_snap_mispredict),
    .running         (s_running),
    .ovf             (s_ovf)
  );

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {ctrl_start, ctrl_stop, ctrl_clear, ev_retire, ev_branch, ev_mispredict, snap_req, snap_ack} = '0;
    {s_start, s_stop, s_clear, s_retire, s_branch, s_mispredict, s_req, s_ack} = '0;
    tick();
    tick();
    chk("reset_running", 32'(running), 32'd0);
    chk("reset_valid", 32'(snap_valid), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_snap_retire", snap_retire, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic window: 10 retires, 3 branches, 1 mispredict.
    ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
    chk("start_running", 32'(running), 32'd1);
    for (int i = 0; i < 10; i++) begin
      ev_retire     = 1'b1;
      ev_branch     = (i < 3);
      ev_mispredict = (i == 0);
      tick();
    end
    {ev_retire, ev_branch, ev_mispredict} = '0;
    ctrl_stop = 1'b1;
    tick();
    ctrl_stop = 1'b0;
    chk("stop_running", 32'(running), 32'd0);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("basic_valid", 32'(snap_valid), 32'd1);
    chk("basic_retire", snap_retire, 32'd10);
    chk("basic_branch", snap_branch, 32'd3);
    chk("basic_mispredict", snap_mispredict, 32'd1);
    snap_ack = 1'b1;
    tick();
    snap_ack = 1'b0;
    chk("ack_valid", 32'(snap_valid), 32'd0);
    chk("ack_retain", snap_retire, 32'd10);

    // Window edges: IDLE and start-cycle events ignored, stop-cycle events counted.
    ctrl_clear = 1'b1;
    tick();
    ctrl_clear = 1'b0;
    {ev_retire, ev_branch, ev_mispredict} = 3'b111;
    tick();
    ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
    {ev_retire, ev_branch, ev_mispredict} = 3'b000;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("edge_start_retire", snap_retire, 32'd0);
    chk("edge_start_branch", snap_branch, 32'd0);
    chk("edge_start_mispredict", snap_mispredict, 32'd0);
    snap_ack = 1'b1;
    tick();
    snap_ack = 1'b0;
    ctrl_stop = 1'b1;
    {ev_retire, ev_branch, ev_mispredict} = 3'b111;
    tick();
    ctrl_stop = 1'b0;
    {ev_retire, ev_branch, ev_mispredict} = 3'b000;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("edge_stop_retire", snap_retire, 32'd1);
    chk("edge_stop_branch", snap_branch, 32'd1);
    chk("edge_stop_mispredict", snap_mispredict, 32'd1);
    snap_ack = 1'b1;
    tick();
    snap_ack = 1'b0;

    // Start and stop together from IDLE: stop wins.
    ctrl_start = 1'b1;
    ctrl_stop  = 1'b1;
    tick();
    {ctrl_start, ctrl_stop} = 2'b00;
    chk("start_stop_same", 32'(running), 32'd0);

    // 4-bit instance: 17 retires.
    s_start = 1'b1;
    tick();
    s_start  = 1'b0;
    s_retire = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    s_retire = 1'b0;
    s_stop = 1'b1;
    tick();
    s_stop = 1'b0;
    s_req = 1'b1;
    tick();
    s_req = 1'b0;
`ifdef PERF_MON_SATURATE_EN
    chk("ovf_snap_retire", 32'(s_snap_retire), 32'd15);
`else
    chk("ovf_snap_retire", 32'(s_snap_retire), 32'd1);
`endif
    chk("ovf_flag", 32'(s_ovf), 32'd1);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    s_clear = 1'b1;
    tick();
    s_clear = 1'b0;
    chk("clear_ovf", 32'(s_ovf), 32'd0);

    // Clear beats a same-cycle increment at count 5.
    s_start = 1'b1;
    tick();
    s_start  = 1'b0;
    s_retire = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    s_retire = 1'b0;
    s_req = 1'b1;
    tick();
    s_req = 1'b0;
    chk("pre_clear_retire", 32'(s_snap_retire), 32'd5);
    s_ack = 1'b1;
    tick();
    s_ack    = 1'b0;
    s_clear  = 1'b1;
    s_retire = 1'b1;
    tick();
    s_clear  = 1'b0;
    s_retire = 1'b0;
    s_req = 1'b1;
    tick();
    s_req = 1'b0;
    chk("clear_beats_inc", 32'(s_snap_retire), 32'd0);
    chk("clear_ovf_after", 32'(s_ovf), 32'd0);
    chk("clear_keeps_running", 32'(s_running), 32'd1);

    // Request during hold is ignored, also in the ack cycle.
    ctrl_clear = 1'b1;
    tick();
    ctrl_clear = 1'b0;
    ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
    ev_retire = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    ev_retire = 1'b0;
    snap_req = 1'b1;
    tick();
    chk("hold_first", snap_retire, 32'd4);
    ev_retire = 1'b1;
    tick();
    tick();
    ev_retire = 1'b0;
    chk("hold_ignored_req", snap_retire, 32'd4);
    chk("hold_valid", 32'(snap_valid), 32'd1);
    snap_ack = 1'b1;
    tick();
    snap_ack = 1'b0;
    chk("hold_ack_valid", 32'(snap_valid), 32'd0);
    chk("hold_ack_retain", snap_retire, 32'd4);
    tick();
    snap_req = 1'b0;
    chk("rereq_valid", 32'(snap_valid), 32'd1);
    chk("rereq_retire", snap_retire, 32'd6);

    // Async reset mid-window with a snapshot held.
    chk("pre_reset_running", 32'(running), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_running", 32'(running), 32'd0);
    chk("async_valid", 32'(snap_valid), 32'd0);
    chk("async_ovf", 32'(ovf), 32'd0);
    chk("async_snap_retire", snap_retire, 32'd0);
    chk("async_snap_branch", snap_branch, 32'd0);
    chk("async_snap_mispredict", snap_mispredict, 32'd0);
    chk("async_s_running", 32'(s_running), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
